aes_inv_key_sched: RTL and testbench
====================================

// Module: aes_inv_key_sched
// PURPOSE
//   Sequential AES-128 decryption key scheduler. It accepts the cipher key and
//   runs the key expansion forward to round 10. It then walks the schedule
//   backward and streams round keys 10,9,...,0 over a valid/ready handshake.
//   It feeds the inverse-cipher datapath, which consumes keys in reverse order.
//   Four shared aes_sbox instances serve both directions; only 128 bits of key
//   state are held, not the 1408-bit flat schedule.
// PARAMETERS
//   SKIP_FWD  0  1: key_in is already the round-10 key; the forward pass is skipped
// PORTS
//   clk       in   1    clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   clear     in   1    synchronous abort; returns to IDLE next cycle
//   key_in    in   128  cipher key (or round-10 key if SKIP_FWD=1); word0 = [127:96]
//   key_valid in   1    key_in valid
//   key_ready out  1    block can accept a key (IDLE only)
//   rk_out    out  128  current round key; word0 = [127:96]
//   rk_round  out  4    round index of rk_out (10 down to 0)
//   rk_valid  out  1    rk_out/rk_round valid
//   rk_ready  in   1    consumer accepts rk_out
//   rk_last   out  1    high with rk_valid when rk_round==0
//   busy      out  1    high in FWD or EMIT
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, key reg=0, round ctr=0, key_ready=1,
//     rk_valid=0, rk_last=0, rk_round=0, rk_out=0, busy=0.
//   States: IDLE -> FWD -> EMIT -> IDLE. SKIP_FWD=1: IDLE -> EMIT directly.
//   IDLE: key_ready=1. On key_valid, latch key_in into the key reg.
//     Set ctr=1 and enter FWD. With SKIP_FWD=1, set ctr=10 and enter EMIT.
//   FWD: one forward round per cycle; ctr increments 1..10.
//     t = SubWord(RotWord(w3)) ^ {rcon(ctr),24'h0}
//     w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
//     After the ctr==10 step, enter EMIT with ctr=10.
//   rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 (MSB byte).
//   EMIT: rk_valid=1, rk_out=key reg, rk_round=ctr, rk_last=(ctr==0).
//     rk_out/rk_round are held stable while rk_valid && !rk_ready.
//     On rk_valid&&rk_ready with ctr>0, apply one inverse step and decrement ctr:
//       p3=w3^w2, p2=w2^w1, p1=w1^w0,
//       p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon(ctr),24'h0}.
//     On rk_valid&&rk_ready with ctr==0: enter IDLE; rk_valid=0 next cycle.
//   Throughput: one key per cycle while rk_ready=1.
//   Latency, SKIP_FWD=0: key handshake at cycle T -> first rk_valid at T+11.
//   Latency, SKIP_FWD=1: key handshake at cycle T -> first rk_valid at T+1.
//   S-box input mux: RotWord(w3) in FWD, RotWord(w3^w2) in EMIT.
//   key_valid outside IDLE is ignored; no key is latched.
//   clear has priority over all handshakes: next cycle state=IDLE, rk_valid=0,
//     busy=0, key_ready=1. The key reg is not required to be zeroed.
//   rst_n asserted mid-FWD or mid-EMIT: outputs take reset values immediately.
//   The output register never wraps; ctr never goes below 0 or above 10.
// TESTING
//   1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//     first rk_valid at T+11 with rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6;
//     rk_round=1 -> a0fafe1788542cb123a339392a6c7605;
//     rk_round=0 -> key itself, with rk_last=1.
//   2 Backpressure: drop rk_ready for 3 cycles at rk_round=7 ->
//     rk_out/rk_round held; the sequence resumes with 6 and no key is skipped.
//   3 SKIP_FWD=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 ->
//     rk_valid at T+1; after 10 handshakes rk_out=2b7e151628aed2a6abf7158809cf4f3c.
//   4 clear pulsed in FWD (ctr=5) and separately in EMIT (rk_round=4) ->
//     next cycle rk_valid=0 and key_ready=1; a fresh key runs test 1 correctly.
//   5 key_valid held high during EMIT -> key ignored.
//     key_ready=1 only the cycle after the rk_last handshake.
//   6 rst_n low mid-EMIT -> all outputs at reset values same cycle;
//     random keys vs. a software reference model: all 11 keys match.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// ---------------------------------------------------------------------------
// aes_inv_key_sched
//   Sequential AES-128 decryption key scheduler. A cipher key is run forward
//   through the key expansion to round 10 (one round per cycle), then the
//   schedule is walked backward and round keys 10..0 are streamed out over a
//   valid/ready handshake. Only one 128-bit round key is stored; the four
//   S-boxes are shared between the forward and the inverse step.
//
//   Parameters
//     SKIP_FWD  1: key_in is already the round-10 key, forward pass skipped
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     clear      synchronous abort back to IDLE
//     key_in     cipher key (round-10 key if SKIP_FWD=1), word0 = [127:96]
//     key_valid  key_in valid
//     key_ready  block can accept a key (IDLE only)
//     rk_out     current round key, word0 = [127:96]
//     rk_round   round index of rk_out (10 down to 0)
//     rk_valid   rk_out/rk_round valid
//     rk_ready   consumer accepts rk_out
//     rk_last    high with rk_valid when rk_round == 0
//     busy       high in FWD or EMIT
//
//   States
//     IDLE | waiting for a key, key_ready high
//     FWD  | forward expansion, ctr = round being produced (1..10)
//     EMIT | streaming round key ctr, stepping backward on each handshake
// ---------------------------------------------------------------------------

// AES S-box computed as GF(2^8) inverse followed by the affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] v);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) p = p ^ m;
            m = xtime(m);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box needs.
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign y = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

module aes_inv_key_sched #(
    parameter int SKIP_FWD = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] key_reg;
    logic [3:0]   ctr;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sbox_in, rot, sub, t;
    logic [7:0]   rcon;
    logic [127:0] fwd_key, inv_key;
    logic         handshake;

    assign w0 = key_reg[127:96];
    assign w1 = key_reg[95:64];
    assign w2 = key_reg[63:32];
    assign w3 = key_reg[31:0];

    // Backward, the previous w3 is recovered as w3^w2 before feeding the S-boxes.
    assign sbox_in = (state == S_EMIT) ? (w3 ^ w2) : w3;
    assign rot     = {sbox_in[23:0], sbox_in[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*b +: 8]),
            .y (sub[8*b +: 8])
        );
    end

    always_comb begin
        rcon = 8'h00;
        case (ctr)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t = sub ^ {rcon, 24'h000000};

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0 = w0 ^ t;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        fwd_key = {f0, f1, f2, f3};
        inv_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    assign handshake = (state == S_EMIT) && rk_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; clear overrides every handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (key_valid) state_nxt = (SKIP_FWD != 0) ? S_EMIT : S_FWD;
            S_FWD:  if (ctr == 4'd10) state_nxt = S_EMIT;
            S_EMIT: if (handshake && ctr == 4'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    // Outputs
    always_comb begin
        key_ready = (state == S_IDLE);
        rk_valid  = (state == S_EMIT);
        rk_last   = (state == S_EMIT) && (ctr == 4'd0);
        busy      = (state == S_FWD) || (state == S_EMIT);
        rk_out    = key_reg;
        rk_round  = ctr;
    end

    // Key register and round counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
            ctr     <= 4'd0;
        end else if (clear) begin
            ctr <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (key_valid) begin
                    key_reg <= key_in;
                    ctr     <= (SKIP_FWD != 0) ? 4'd10 : 4'd1;
                end
                S_FWD: begin
                    key_reg <= fwd_key;
                    // Round 10 is both the last forward result and the first emitted key.
                    if (ctr != 4'd10) ctr <= ctr + 4'd1;
                end
                S_EMIT: if (handshake && ctr != 4'd0) begin
                    key_reg <= inv_key;
                    ctr     <= ctr - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, clear;
    logic [127:0] key_in;
    logic         key_valid, key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid, rk_ready, rk_last, busy;

    logic [127:0] s_key_in;
    logic         s_key_valid, s_key_ready;
    logic [127:0] s_rk_out;
    logic [3:0]   s_rk_round;
    logic         s_rk_valid, s_rk_ready, s_rk_last, s_busy;
    logic         s_clear;

    aes_inv_key_sched #(.SKIP_FWD(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy)
    );

    aes_inv_key_sched #(.SKIP_FWD(1)) dut_skip (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .key_in(s_key_in), .key_valid(s_key_valid), .key_ready(s_key_ready),
        .rk_out(s_rk_out), .rk_round(s_rk_round), .rk_valid(s_rk_valid),
        .rk_ready(s_rk_ready), .rk_last(s_rk_last), .busy(s_busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    logic [7:0] sbox_t [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0]   rcon_t [11];
    logic [127:0] exp_rk [11];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
    endfunction

    // Textbook full expansion into 44 words; round r key = words 4r..4r+3.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = sub_rot(tmp) ^ {rcon_t[i/4], 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic send_key(input string tag, input logic [127:0] k);
        chk({tag, "_key_ready"}, key_ready, 1'b1);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Called just after the key handshake edge; reports latency in cycles.
    task automatic wait_valid(input string tag, input int lat);
        int n = 1;
        while (rk_valid !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, lat);
    endtask

    // Consume all 11 round keys, comparing against exp_rk.
    task automatic stream(input string tag, input int stall_at, input bit rand_rdy);
        int r = 10;
        int cyc = 0;
        int stalls = 0;
        while (r >= 0 && cyc < 200) begin
            chk({tag, "_valid"}, rk_valid, 1'b1);
            chk({tag, "_round"}, rk_round, r);
            chk({tag, "_key"}, rk_out, exp_rk[r]);
            chk({tag, "_last"}, rk_last, (r == 0));
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_kready_emit"}, key_ready, 1'b0);
            if (r == stall_at && stalls < 3) begin
                rk_ready = 1'b0;
                stalls++;
            end else if (rand_rdy) begin
                rk_ready = 1'($urandom_range(0, 1));
            end else begin
                rk_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (rk_ready) r--;
        end
        rk_ready = 1'b1;
        chk({tag, "_all_keys"}, r, -1);
        chk({tag, "_valid_after"}, rk_valid, 1'b0);
        chk({tag, "_kready_after"}, key_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] ka, kb;

        rcon_t[0] = 8'h00;
        rcon_t[1] = 8'h01;
        for (int i = 2; i < 11; i++)
            rcon_t[i] = {rcon_t[i-1][6:0], 1'b0} ^ (rcon_t[i-1][7] ? 8'h1b : 8'h00);

        rst_n = 1'b0; clear = 1'b0; key_in = '0; key_valid = 1'b0; rk_ready = 1'b1;
        s_clear = 1'b0; s_key_in = '0; s_key_valid = 1'b0; s_rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rk_valid, 1'b0);
        chk("rst_kready", key_ready, 1'b1);
        chk("rst_round", rk_round, 4'd0);
        chk("rst_out", rk_out, 128'h0);
        chk("rst_last", rk_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 key, free-flowing consumer
        model_expand(FIPS_KEY);
        send_key("t1", FIPS_KEY);
        chk("t1_busy_fwd", busy, 1'b1);
        wait_valid("t1", 11);
        chk("t1_r10_fips", rk_out, FIPS_R10);
        chk("t1_r1_model_fips", exp_rk[1], FIPS_R1);
        stream("t1", -1, 1'b0);

        // Backpressure at round 7
        model_expand({$urandom, $urandom, $urandom, $urandom});
        send_key("t2", {exp_rk[0]});
        wait_valid("t2", 11);
        stream("t2", 7, 1'b0);

        // SKIP_FWD instance fed the round-10 key
        chk("t3_kready", s_key_ready, 1'b1);
        s_key_in = FIPS_R10;
        s_key_valid = 1'b1;
        @(posedge clk); #1;
        s_key_valid = 1'b0;
        chk("t3_valid_t1", s_rk_valid, 1'b1);
        chk("t3_round10", s_rk_round, 4'd10);
        chk("t3_out10", s_rk_out, FIPS_R10);
        repeat (9) begin @(posedge clk); #1; end
        chk("t3_round1", s_rk_round, 4'd1);
        chk("t3_out1", s_rk_out, FIPS_R1);
        @(posedge clk); #1;
        chk("t3_round0", s_rk_round, 4'd0);
        chk("t3_out0", s_rk_out, FIPS_KEY);
        chk("t3_last", s_rk_last, 1'b1);
        @(posedge clk); #1;
        chk("t3_valid_end", s_rk_valid, 1'b0);
        chk("t3_kready_end", s_key_ready, 1'b1);

        // clear during FWD (ctr=5) and during EMIT (round 4)
        model_expand(FIPS_KEY);
        send_key("t4a", FIPS_KEY);
        repeat (4) begin @(posedge clk); #1; end
        chk("t4_fwd_ctr", rk_round, 4'd5);
        chk("t4_fwd_busy", busy, 1'b1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t4_fwd_clr_valid", rk_valid, 1'b0);
        chk("t4_fwd_clr_kready", key_ready, 1'b1);
        chk("t4_fwd_clr_busy", busy, 1'b0);
        send_key("t4b", FIPS_KEY);
        wait_valid("t4b", 11);
        rk_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("t4_emit_round", rk_round, 4'd4);
        chk("t4_emit_key", rk_out, exp_rk[4]);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t4_emit_clr_valid", rk_valid, 1'b0);
        chk("t4_emit_clr_kready", key_ready, 1'b1);
        chk("t4_emit_clr_busy", busy, 1'b0);
        send_key("t4c", FIPS_KEY);
        wait_valid("t4c", 11);
        chk("t4c_r10_fips", rk_out, FIPS_R10);
        stream("t4c", -1, 1'b0);

        // key_valid held high through EMIT
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        model_expand(ka);
        send_key("t5a", ka);
        wait_valid("t5a", 11);
        key_in = kb;
        key_valid = 1'b1;
        stream("t5a", -1, 1'b0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("t5_kready_taken", key_ready, 1'b0);
        chk("t5_busy_taken", busy, 1'b1);
        model_expand(kb);
        wait_valid("t5b", 11);
        stream("t5b", -1, 1'b0);

        // async reset mid-EMIT
        model_expand({$urandom, $urandom, $urandom, $urandom});
        send_key("t6", exp_rk[0]);
        wait_valid("t6", 11);
        rk_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", rk_valid, 1'b0);
        chk("t6_rst_kready", key_ready, 1'b1);
        chk("t6_rst_round", rk_round, 4'd0);
        chk("t6_rst_out", rk_out, 128'h0);
        chk("t6_rst_last", rk_last, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        #1;
        rst_n = 1'b1;

        // random keys with random consumer backpressure
        for (int k = 0; k < 4; k++) begin
            model_expand({$urandom, $urandom, $urandom, $urandom});
            send_key("t6r", exp_rk[0]);
            wait_valid("t6r", 11);
            stream("t6r", -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
